// File: rtl/sii_pio_irq_in.sv
// sii_pio_irq_in -- Avalon-MM parallel input port with per-bit edge capture
// and level interrupt.
//
// Each in_port bit is synchronized, optionally debounced, then edge-detected.
// Enabled rising/falling edges set sticky edge_capture bits (write-1-to-clear).
// irq is the OR of edge_capture & irq_mask.
//
// Compile-time option: define SII_PIO_DEBOUNCE_EN to build one debounce
// counter per bit. Without it the filtered value is the synchronizer output.
module sii_pio_irq_in #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_pipe_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d_reg;
    logic [WIDTH-1:0] rise_en_reg;
    logic [WIDTH-1:0] fall_en_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [WIDTH-1:0] edge_capture_next;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] clear_vec;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic [31:0]      read_next;

    // Multi-flop synchronizer for the asynchronous inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_pipe_reg[s] <= '0;
            end
        end else begin
            sync_pipe_reg[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_pipe_reg[s] <= sync_pipe_reg[s-1];
            end
        end
    end

    assign sync = sync_pipe_reg[SYNC_STAGES-1];

`ifdef SII_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             filt_bit_reg;

            // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg      <= '0;
                    filt_bit_reg <= 1'b0;
                end else if (sync[gi] == filt_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_bit_reg <= sync[gi];
                    cnt_reg      <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign filt[gi] = filt_bit_reg;
        end
    endgenerate
`else
    assign filt = sync;
`endif

    assign wr_en      = chipselect & ~write_n;
    assign wdata      = writedata[WIDTH-1:0];
    assign edge_event = (filt & ~filt_d_reg & rise_en_reg) |
                        (~filt & filt_d_reg & fall_en_reg);
    assign clear_vec  = (wr_en && address == 3'd3) ? wdata : '0;
    // A new event overrides a simultaneous clear of the same bit
    assign edge_capture_next = (edge_capture_reg & ~clear_vec) | edge_event;
    assign pending    = edge_capture_reg & irq_mask_reg;
    assign irq        = |pending;

    // Control registers, edge history and sticky capture bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_d_reg       <= '0;
            rise_en_reg      <= '0;
            fall_en_reg      <= '0;
            irq_mask_reg     <= '0;
            edge_capture_reg <= '0;
        end else begin
            filt_d_reg       <= filt;
            edge_capture_reg <= edge_capture_next;
            if (wr_en) begin
                case (address)
                    3'd1:    rise_en_reg  <= wdata;
                    3'd2:    irq_mask_reg <= wdata;
                    3'd4:    fall_en_reg  <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Address-selected read value, zero-extended
    always_comb begin
        read_next = '0;
        case (address)
            3'd0:    read_next[WIDTH-1:0] = filt;
            3'd1:    read_next[WIDTH-1:0] = rise_en_reg;
            3'd2:    read_next[WIDTH-1:0] = irq_mask_reg;
            3'd3:    read_next[WIDTH-1:0] = edge_capture_reg;
            3'd4:    read_next[WIDTH-1:0] = fall_en_reg;
            3'd5:    read_next[WIDTH-1:0] = pending;
            default: read_next = '0;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= read_next;
        end
    end

endmodule

// File: tb/tb_sii_pio_irq_in.sv
// Directed self-checking bench for sii_pio_irq_in (WIDTH=4, SYNC_STAGES=2).
module tb_sii_pio_irq_in;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DBC   = 4;
`ifdef SII_PIO_DEBOUNCE_EN
    localparam int DB = DBC;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = SYNC + 1 + DB;

    logic             clk;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    sii_pio_irq_in #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    initial begin
        logic [31:0] v;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        cyc(2);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        tick();

        // Default rise_en is 0 after reset
        rd(3'd1, v); check("rise_en_dflt", v, 32'h0);

        // Rising edge on bit0 with exact latency
        wr(3'd1, 32'hF);
        wr(3'd2, 32'h1);
        rd(3'd1, v); check("rise_en_rd", v, 32'hF);
        in_port = 4'h1;
        cyc(LAT - 1);
        check("rise_early_irq", {31'h0, irq}, 32'h0);
        tick();
        check("rise_irq", {31'h0, irq}, 32'h1);
        rd(3'd3, v); check("rise_capture", v, 32'h1);
        rd(3'd0, v); check("data_rd", v, 32'h1);
        wr(3'd3, 32'h1);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        rd(3'd3, v); check("w1c_capture", v, 32'h0);

        // Writes to read-only addresses are ignored
        wr(3'd0, 32'hF);
        rd(3'd0, v); check("ro_data", v, 32'h1);
        wr(3'd5, 32'hF);
        rd(3'd5, v); check("ro_pending", v, 32'h0);

        // Falling-edge-only capture on bit1, upper writedata ignored
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h2);
        wr(3'd2, 32'hFFFF_FFF2);
        rd(3'd2, v); check("mask_trunc", v, 32'h2);
        in_port = 4'h3;
        cyc(LAT + 2);
        check("fall_rise_irq", {31'h0, irq}, 32'h0);
        rd(3'd3, v); check("fall_rise_cap", v, 32'h0);
        in_port = 4'h1;
        cyc(LAT - 1);
        check("fall_early_irq", {31'h0, irq}, 32'h0);
        tick();
        check("fall_irq", {31'h0, irq}, 32'h1);
        rd(3'd5, v); check("pending_rd", v, 32'h2);
        rd(3'd3, v); check("fall_capture", v, 32'h2);
        wr(3'd3, 32'hF);
        rd(3'd3, v); check("fall_clear", v, 32'h0);

        // Event and clear in the same cycle: event wins
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h1);
        in_port = 4'h0;
        cyc(LAT + 2);
        rd(3'd3, v); check("same_pre", v, 32'h0);
        in_port = 4'h1;
        cyc(LAT - 1);
        wr(3'd3, 32'h1);
        rd(3'd3, v); check("same_cycle_cap", v, 32'h1);
        check("same_cycle_irq", {31'h0, irq}, 32'h1);

        // Enable changes keep existing bits; disabled bits never set
        wr(3'd1, 32'h0);
        rd(3'd3, v); check("en_change_keep", v, 32'h1);
        wr(3'd4, 32'h0);
        wr(3'd3, 32'hF);
        in_port = 4'h5;
        cyc(LAT + 2);
        in_port = 4'h1;
        cyc(LAT + 2);
        rd(3'd3, v); check("no_enable_cap", v, 32'h0);

        // Unused addresses read zero
        rd(3'd2, v); check("mask_rd", v, 32'h1);
        rd(3'd6, v); check("addr6_zero", v, 32'h0);
        rd(3'd7, v); check("addr7_zero", v, 32'h0);

`ifdef SII_PIO_DEBOUNCE_EN
        // Short pulse is filtered, full-length pulse is captured
        wr(3'd1, 32'h4);
        wr(3'd2, 32'h4);
        in_port = 4'h5;
        cyc(DB - 1);
        in_port = 4'h1;
        cyc(LAT + 4);
        rd(3'd3, v); check("db_short_pulse", v, 32'h0);
        in_port = 4'h5;
        cyc(DB);
        in_port = 4'h1;
        cyc(LAT - 1 - DB);
        check("db_early_irq", {31'h0, irq}, 32'h0);
        tick();
        check("db_pulse_irq", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'hF);
        wr(3'd1, 32'h0);
        cyc(LAT + 4);
`endif

        // Reset mid-flight with bit3 held high through release
        in_port = 4'h0;
        cyc(LAT + 2);
        in_port = 4'h8;
        rd(3'd2, v); check("pre_rst_mask", v, 32'h1);
        tick();
        reset = 1'b1;
        #1;
        check("async_rst_rd", readdata, 32'h0);
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        cyc(2);
        reset = 1'b0;
        wr(3'd1, 32'h8);
        cyc(LAT - 2);
        rd(3'd3, v); check("rst_rel_early", v, 32'h0);
        rd(3'd3, v); check("rst_rel_cap", v, 32'h8);
        rd(3'd2, v); check("rst_mask_zero", v, 32'h0);
        rd(3'd4, v); check("rst_fall_zero", v, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sii_pio_irq_in.md
SII_PIO_IRQ_IN -- requirements
Module: sii_pio_irq_in

Interface
REQ-001 Parameter WIDTH, default 1: number of input bits, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops per bit, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: number of stable cycles required before a filtered bit changes, legal range 1..65535.
REQ-004 clk  in  1  single clock; all state SHALL be synchronous to its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  3  Avalon register select.
REQ-007 chipselect  in  1  Avalon select.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data; bits [31:WIDTH] SHALL be ignored.
REQ-010 in_port  in  WIDTH  asynchronous external inputs.
REQ-011 readdata  out  32  registered read data; bits [31:WIDTH] SHALL read 0.
REQ-012 irq  out  1  level interrupt request.

Function
REQ-013 Register map: 0 = filtered data (read-only); 1 = rise_en (R/W); 2 = irq_mask (R/W); 3 = edge_capture (R, write-1-to-clear); 4 = fall_en (R/W); 5 = pending = edge_capture & irq_mask (read-only); 6 and 7 SHALL read 0.
REQ-014 A write SHALL occur when chipselect=1 and write_n=0; writes to read-only addresses SHALL have no effect.
REQ-015 readdata SHALL be updated on every clock edge from the address-selected register (1-cycle latency), independent of chipselect.
REQ-016 Each in_port bit SHALL pass through a SYNC_STAGES-deep synchronizer to produce sync[i].
REQ-017 filt[i] SHALL be the debounced sync[i] (REQ-029/030); filt_d[i] SHALL be filt[i] delayed by one cycle.
REQ-018 rise[i] = filt[i] & ~filt_d[i]; fall[i] = ~filt[i] & filt_d[i]; event[i] = (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]).
REQ-019 edge_capture[i] SHALL be set on the edge following event[i] and SHALL hold until cleared.
REQ-020 A write to address 3 SHALL clear exactly those bits with writedata[i]=1.
REQ-021 If event[i] and a clear of bit i occur in the same cycle, edge_capture[i] SHALL end set (the event wins).
REQ-022 irq = |(edge_capture & irq_mask), decoded from registers only, with no input-path combinational term.
REQ-023 Latency: the set edge of edge_capture SHALL be SYNC_STAGES+1 clock edges after in_port is first sampled at its new level, plus DEBOUNCE_CYCLES when debouncing is compiled in.
REQ-024 A capture bit whose rise_en and fall_en are both 0 SHALL never set; changing rise_en or fall_en SHALL NOT alter existing capture bits.

Reset
REQ-025 On reset assertion: readdata, rise_en, fall_en, irq_mask, edge_capture, all synchronizer flops, filt, filt_d and debounce counters SHALL clear to 0 immediately; irq SHALL be 0.
REQ-026 The default rise_en after reset SHALL be 0; software enables edges explicitly.
REQ-027 Reset asserted mid-debounce SHALL discard any partial count; no event SHALL be generated on reset release.
REQ-028 An in_port bit held at 1 through reset release SHALL produce a rise event after the normal latency.

Configuration
REQ-029 Macro SII_PIO_DEBOUNCE_EN defined: each bit has a counter of width clog2(DEBOUNCE_CYCLES+1); the counter increments while sync[i] != filt[i] and returns to 0 when they agree; filt[i] <= sync[i] and the counter returns to 0 on the edge at which the difference has held for DEBOUNCE_CYCLES consecutive samples.
REQ-030 Macro undefined: no counters are built; filt[i] = sync[i] combinationally; DEBOUNCE_CYCLES is ignored.

Verification
REQ-031 WIDTH=4, macro off, rise_en=0xF, mask=0x1: in_port 0->0x1 -> edge_capture=0x1 at edge 3, irq=1; write 0x1 to address 3 -> irq=0.
REQ-032 fall_en=0x2 only: in_port bit1 rises then falls -> capture is set only after the fall; reading address 5 returns 0x2 when mask=0x2.
REQ-033 Same-cycle event on bit0 and W1C of 0x1 -> edge_capture[0]=1 afterwards.
REQ-034 Macro on, DEBOUNCE_CYCLES=4: a 3-cycle pulse -> no capture; a 4-cycle pulse -> capture at edge SYNC_STAGES+5.
REQ-035 Reset asserted mid-count, in_port held at 1, reset released -> all registers 0, then capture=1 after the full latency; address 6 reads 0.
